uart_block_rx: RTL and testbench

Upstream stage of the UART/AES decryption path: oversamples the serial input line, recovers 8N1 UART bytes and packs 16 consecutive bytes into one 128-bit ciphertext block for the decryption core. A single-cycle valid pulse accompanies each completed block. The block also handles start-bit glitches, framing errors and stalled partial blocks, so a corrupted transfer never produces a misaligned block.

---
 rtl/uart_aes_pkg.sv | 18 +
 rtl/uart_rx_byte.sv | 116 +++++++++++
 rtl/uart_block_rx.sv | 94 +++++++++
 tb/tb_uart_block_rx.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_aes_pkg.sv
// Shared definitions for the UART-to-AES receive path.
// Holds the byte FSM state encoding, default bit timing and block geometry.
package uart_aes_pkg;

   localparam int unsigned CLKS_PER_BIT_DEF    = 868;  // 100 MHz / 115200 baud
   localparam int unsigned BYTES_PER_BLOCK_DEF = 16;
   localparam int unsigned TIMEOUT_BITS_DEF    = 64;
   localparam int unsigned BLOCK_W             = 8 * BYTES_PER_BLOCK_DEF;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_START     = 3'd1,
      ST_DATA      = 3'd2,
      ST_STOP      = 3'd3,
      ST_WAIT_IDLE = 3'd4
   } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver with 2-FF input synchronizer and mid-bit sampling.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   data_in      raw serial line (idles high)
//   byte_valid   same-cycle strobe: stop bit sampled high, byte_data complete
//   byte_data    received byte, LSB received first
//   frame_err    same-cycle strobe: stop bit sampled low
//   idle_c       FSM currently in IDLE
module uart_rx_byte
   import uart_aes_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       data_in,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       frame_err,
   output logic       idle_c
);

   localparam int unsigned CLK_W = $clog2(CLKS_PER_BIT);

   rx_state_t        state, state_n;
   logic             sync1, sync2;
   logic [CLK_W-1:0] clk_cnt;
   logic [2:0]       bit_cnt;
   logic             cnt_clr;
   logic             sample_bit;
   logic             half_done;
   logic             full_done;

   // Synchronizer flops reset to the idle-line level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= data_in;
         sync2 <= sync1;
      end
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_n;
   end

   assign half_done = (clk_cnt == CLK_W'(CLKS_PER_BIT / 2 - 1));
   assign full_done = (clk_cnt == CLK_W'(CLKS_PER_BIT - 1));

   // Next-state and strobe decode
   always_comb begin
      state_n    = state;
      cnt_clr    = 1'b0;
      sample_bit = 1'b0;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      case (state)
         ST_IDLE: begin
            cnt_clr = 1'b1;
            if (!sync2) state_n = ST_START;
         end
         ST_START: begin
            if (half_done) begin
               cnt_clr = 1'b1;
               // A line that is high again at mid start bit was a glitch
               state_n = sync2 ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (full_done) begin
               cnt_clr    = 1'b1;
               sample_bit = 1'b1;
               if (bit_cnt == 3'd7) state_n = ST_STOP;
            end
         end
         ST_STOP: begin
            if (full_done) begin
               cnt_clr = 1'b1;
               if (sync2) begin
                  byte_valid = 1'b1;
                  state_n    = ST_IDLE;
               end else begin
                  frame_err = 1'b1;
                  state_n   = ST_WAIT_IDLE;
               end
            end
         end
         ST_WAIT_IDLE: begin
            cnt_clr = 1'b1;
            if (sync2) state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Bit timing counter, bit counter and data shift register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_cnt   <= '0;
         bit_cnt   <= '0;
         byte_data <= '0;
      end else begin
         clk_cnt <= cnt_clr ? '0 : clk_cnt + CLK_W'(1);
         if (state == ST_IDLE) bit_cnt <= '0;
         else if (sample_bit)  bit_cnt <= bit_cnt + 3'd1;
         if (sample_bit) byte_data <= {sync2, byte_data[7:1]};
      end
   end

   assign idle_c = (state == ST_IDLE);

endmodule

// File: rtl/uart_block_rx.sv
// Packs received UART bytes into ciphertext blocks for the decryption core.
// Ports:
//   clk, rst_n    clock, async active-low reset
//   data_in       UART serial line (idles high)
//   data_out_rx   last completed block, first byte in the top byte
//   data_state    one-cycle pulse when data_out_rx is updated
//   frame_err     one-cycle pulse on a low stop bit
//   timeout_err   one-cycle pulse when a stalled partial block is dropped
module uart_block_rx
   import uart_aes_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT    = CLKS_PER_BIT_DEF,
   parameter int unsigned BYTES_PER_BLOCK = BYTES_PER_BLOCK_DEF,
   parameter int unsigned TIMEOUT_BITS    = TIMEOUT_BITS_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         data_in,
   output logic [8*BYTES_PER_BLOCK-1:0] data_out_rx,
   output logic                         data_state,
   output logic                         frame_err,
   output logic                         timeout_err
);

   localparam int unsigned BLK_W      = 8 * BYTES_PER_BLOCK;
   localparam int unsigned CNT_W      = $clog2(BYTES_PER_BLOCK);
   localparam int unsigned TO_CYCLES  = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int unsigned IDLE_W     = $clog2(TO_CYCLES);

   logic             byte_valid;
   logic [7:0]       byte_data;
   logic             rx_frame_err;
   logic             rx_idle;
   logic [BLK_W-1:0] shift_reg;
   logic [BLK_W-1:0] shift_next;
   logic [CNT_W-1:0] byte_cnt;
   logic [IDLE_W-1:0] idle_cnt;
   logic             idle_run;
   logic             timeout_hit;

   uart_rx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_rx_byte (
      .clk        (clk),
      .rst_n      (rst_n),
      .data_in    (data_in),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .frame_err  (rx_frame_err),
      .idle_c     (rx_idle)
   );

   assign shift_next  = {shift_reg[BLK_W-9:0], byte_data};
   // Idle counter only runs while a partial block is waiting in IDLE
   assign idle_run    = rx_idle && (byte_cnt != '0);
   assign timeout_hit = idle_run && (idle_cnt == IDLE_W'(TO_CYCLES - 1));

   // Block assembly, stall timeout and registered output pulses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_reg   <= '0;
         byte_cnt    <= '0;
         idle_cnt    <= '0;
         data_out_rx <= '0;
         data_state  <= 1'b0;
         frame_err   <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         data_state  <= 1'b0;
         frame_err   <= rx_frame_err;
         timeout_err <= 1'b0;
         idle_cnt    <= idle_run ? idle_cnt + IDLE_W'(1) : '0;

         // An accepted byte wins over any concurrent timeout
         if (byte_valid) begin
            shift_reg <= shift_next;
            if (byte_cnt == CNT_W'(BYTES_PER_BLOCK - 1)) begin
               data_out_rx <= shift_next;
               data_state  <= 1'b1;
               byte_cnt    <= '0;
            end else begin
               byte_cnt <= byte_cnt + CNT_W'(1);
            end
         end else if (rx_frame_err) begin
            byte_cnt <= '0;
         end else if (timeout_hit) begin
            byte_cnt    <= '0;
            idle_cnt    <= '0;
            timeout_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_block_rx.sv
// Directed bench for uart_block_rx with a block scoreboard and pulse monitor.
module tb_uart_block_rx;

   localparam int unsigned CPB = 16;
   localparam int unsigned NB  = 16;
   localparam int unsigned TOB = 64;
   // Start-bit drive edge to data_state visible: 2 sync + 1 detect + half bit + 9 bits
   localparam int unsigned LAT = 3 + CPB / 2 + 9 * CPB;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         data_in = 1'b1;
   logic [127:0] data_out_rx;
   logic         data_state;
   logic         frame_err;
   logic         timeout_err;

   uart_block_rx #(
      .CLKS_PER_BIT    (CPB),
      .BYTES_PER_BLOCK (NB),
      .TIMEOUT_BITS    (TOB)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .data_in     (data_in),
      .data_out_rx (data_out_rx),
      .data_state  (data_state),
      .frame_err   (frame_err),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] data;
      int unsigned  due;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int unsigned n_ds = 0;
   int unsigned n_fe = 0;
   int unsigned n_to = 0;
   logic        prev_ds = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   // Scoreboard monitor: every data_state pulse must match the oldest expected block
   always @(negedge clk) begin
      if (rst_n) begin
         if (prev_ds) chk("ds_width", 128'(data_state), 128'(0));
         if (frame_err)   n_fe++;
         if (timeout_err) n_to++;
         if (data_state) begin
            n_ds++;
            chk("ds_expected", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               chk("block_data", data_out_rx, e.data);
               chk("block_cycle", 128'(cyc), 128'(e.due));
            end
         end
         prev_ds <= data_state;
      end else begin
         prev_ds <= 1'b0;
      end
   end

   int unsigned last_start;

   task automatic drive_bit(input logic v);
      data_in = v;
      repeat (CPB) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_ok);
      last_start = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop_ok);
   endtask

   // Sends bytes lo..hi of blk; the block is expected when byte NB-1 is sent
   task automatic send_range(input logic [127:0] blk, input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         if (i == NB - 1) begin
            exp_t e;
            e.data = blk;
            e.due  = cyc + LAT;
            sb.push_back(e);
         end
         send_byte(blk[127-8*i -: 8], 1'b1);
      end
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk(tag, 128'(sb.size()), 128'(0));
   endtask

   function automatic logic [127:0] rnd_block();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   logic [127:0] b1, b2, b3, b4, b5, b6, b7;

   initial begin
      b1 = 128'h54776f204f6e65204e696e652054776f;
      b2 = rnd_block();
      b3 = rnd_block();
      b4 = rnd_block();
      b5 = rnd_block();
      b6 = rnd_block();
      b7 = rnd_block();

      // Reset state
      repeat (4) @(posedge clk);
      #1;
      chk("rst_data", data_out_rx, 128'(0));
      chk("rst_ds", 128'(data_state), 128'(0));
      chk("rst_fe", 128'(frame_err), 128'(0));
      chk("rst_to", 128'(timeout_err), 128'(0));
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1;

      // Single block
      send_range(b1, 0, NB - 1);
      drain("single_drain");
      chk("single_count", 128'(n_ds), 128'(1));

      // Start-bit glitch in the middle of a block
      send_range(b2, 0, 2);
      data_in = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      data_in = 1'b1;
      repeat (3 * CPB) @(posedge clk);
      #1;
      chk("glitch_fe", 128'(n_fe), 128'(0));
      chk("glitch_to", 128'(n_to), 128'(0));
      send_range(b2, 3, NB - 1);
      drain("glitch_drain");

      // Framing error after 5 good bytes
      send_range(b3, 0, 4);
      send_byte(8'hA5, 1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      chk("frame_fe", 128'(n_fe), 128'(1));
      chk("frame_hold", data_out_rx, b2);
      send_range(b3, 0, NB - 1);
      drain("frame_drain");

      // Timeout of a 7-byte partial block
      send_range(b4, 0, 6);
      repeat (980) @(posedge clk);
      #1;
      chk("to_early", 128'(n_to), 128'(0));
      repeat (100) @(posedge clk);
      #1;
      chk("to_fired", 128'(n_to), 128'(1));
      chk("to_hold", data_out_rx, b3);
      send_range(b4, 0, NB - 1);
      drain("to_drain");

      // Reset during bit 3 of byte 9
      send_range(b5, 0, 7);
      data_in = 1'b0;
      for (int i = 0; i < 3; i++) drive_bit(b5[127-8*8-(7-i)]);
      data_in = b5[127-8*8-4];
      repeat (5) @(posedge clk);
      #1;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      data_in = 1'b1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rmid_data", data_out_rx, 128'(0));
      chk("rmid_ds", 128'(data_state), 128'(0));
      chk("rmid_fe", 128'(frame_err), 128'(0));
      chk("rmid_to", 128'(timeout_err), 128'(0));
      send_range(b5, 0, NB - 1);
      drain("rmid_drain");

      // Two blocks with no inter-frame gap
      send_range(b6, 0, NB - 1);
      send_range(b7, 0, NB - 1);
      drain("b2b_drain");

      chk("total_blocks", 128'(n_ds), 128'(7));
      chk("total_fe", 128'(n_fe), 128'(1));
      chk("total_to", 128'(n_to), 128'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
